// File: rtl/pc_fetch_gen.sv
// Instruction-fetch PC generator: boot delay, imem ready handshake, pending-redirect buffer.
// Optional redirect alignment check enabled by defining PC_ALIGN_CHK_EN.
module pc_fetch_gen #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
  parameter int                INST_BYTES = 4,
  parameter int                STALL_W    = 6,
  parameter int                BOOT_DLY   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  new_pc,
  input  logic               branch_flag_i,
  input  logic [ADDR_W-1:0]  branch_target_address_i,
  input  logic               imem_ready,
  output logic [ADDR_W-1:0]  pc,
  output logic               ce,
  output logic               redirect_pending_o,
  output logic               misalign_o
);

  typedef enum logic {BOOT, RUN} state_e;

  localparam logic [3:0]        CNT_TERM = 4'(BOOT_DLY - 1);
  localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(INST_BYTES);
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INST_BYTES - 1);

  state_e            state_q, state_nxt;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] pc_q, pc_nxt;
  logic              pend_vld_q, pend_vld_nxt;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_nxt;
  logic              redir;
  logic [ADDR_W-1:0] redir_tgt;
  logic              adv;
  logic              stall_unused;

  // Only the fetch-stage bit of the CTRL stall vector matters here.
  assign stall_unused = ^stall[STALL_W-1:0];
  assign adv          = ~stall[0] & imem_ready;

  // State register and boot counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      if (state_q == BOOT) cnt_q <= cnt_q + 4'd1;
      else                 cnt_q <= '0;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      BOOT:    if (cnt_q == CNT_TERM) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  always_comb begin
    ce                 = (state_q == RUN);
    pc                 = pc_q;
    redirect_pending_o = pend_vld_q;
  end

  // Redirect selection; flush beats branch beats buffered target beats sequential advance.
  always_comb begin
    pc_nxt       = pc_q;
    pend_vld_nxt = pend_vld_q;
    pend_tgt_nxt = pend_tgt_q;
    redir        = 1'b0;
    redir_tgt    = pend_tgt_q;
    if (state_q == BOOT) begin
      pc_nxt       = RESET_VEC;
      pend_vld_nxt = 1'b0;
      pend_tgt_nxt = '0;
    end else if (flush) begin
      redir        = 1'b1;
      redir_tgt    = new_pc;
      pend_vld_nxt = 1'b0;
    end else if (branch_flag_i && adv) begin
      redir        = 1'b1;
      redir_tgt    = branch_target_address_i;
      pend_vld_nxt = 1'b0;
    end else if (branch_flag_i) begin
      pend_vld_nxt = 1'b1;
      pend_tgt_nxt = branch_target_address_i;
    end else if (pend_vld_q && adv) begin
      redir        = 1'b1;
      redir_tgt    = pend_tgt_q;
      pend_vld_nxt = 1'b0;
    end else if (adv) begin
      pc_nxt = pc_q + STRIDE;
    end
    if (redir) begin
`ifdef PC_ALIGN_CHK_EN
      pc_nxt = redir_tgt & ~LOW_MASK;
`else
      pc_nxt = redir_tgt;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_VEC;
      pend_vld_q <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      pc_q       <= pc_nxt;
      pend_vld_q <= pend_vld_nxt;
      pend_tgt_q <= pend_tgt_nxt;
    end
  end

`ifdef PC_ALIGN_CHK_EN
  // Pulses alongside the aligned pc, i.e. checked at apply time, not latch time.
  logic mis_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mis_q <= 1'b0;
    else      mis_q <= redir && ((redir_tgt & LOW_MASK) != '0);
  end
  assign misalign_o = mis_q;
`else
  logic              mis_unused;
  logic [ADDR_W-1:0] mask_unused;
  assign mis_unused  = redir;
  assign mask_unused = LOW_MASK;
  assign misalign_o  = 1'b0;
`endif

endmodule
